fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised next-generation fetch stage: issues in-order instruction requests to an external instruction memory, buffers returned words in a DEPTH-entry prefetch queue, and presents {pc, pc+4, instr} to decode under a valid/ready handshake. Replaces the single-word, local-array fetch with a latency-tolerant, credit-limited pipeline supporting branch redirect with in-flight response squashing and halt. Sits between the imem port and the IF/ID register.

## Interface
- XLEN, 32, address/data width
- DEPTH, 4, prefetch queue entries and max outstanding requests (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, pc loaded at reset
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- redirect  in  1  branch/jump taken (flush), one-cycle pulse
- redirect_pc  in  XLEN  redirect target
- halt  in  1  stop issuing new requests while high
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address (byte-addressed, [1:0]=0)
- imem_rsp_valid  in  1  response valid, strictly in request order, no backpressure
- imem_rsp_data  in  XLEN  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts (low = stall)
- out_instr  out  XLEN  instruction
- out_pc  out  XLEN  address of out_instr
- out_pc_4  out  XLEN  out_pc + 4 (link value)
- out_trap  out  1  head entry is an instruction-address-misaligned trap

## Operation
- State machine: RUN, HALTED, TRAP (TRAP only with FETCH_MISALIGN_TRAP_EN). Reset → RUN.
- RUN: imem_req_valid = !halt && !redirect && (count + inflight < DEPTH); addr = fetch_pc; on fire fetch_pc += 4, inflight += 1.
- halt high → HALTED: no new requests; outstanding responses still accepted and queued; halt low → RUN.
- Response: if drop_cnt > 0, discard and drop_cnt −= 1; else push {rsp_pc, data, trap=0}, rsp_pc += 4. Every response decrements inflight.
- Pop on out_valid && out_ready. Simultaneous push and pop allowed; count unchanged. Credit check prevents overflow; push into full queue cannot occur.
- Redirect (highest priority, any state except reset): queue cleared, fetch_pc and rsp_pc ← redirect_pc, drop_cnt ← inflight − (imem_rsp_valid ? 1 : 0) (response arriving in redirect cycle is discarded), no request that cycle, state → RUN (or TRAP, see Configuration).
- Redirect while halt high: pcs updated, state → HALTED.
- Arithmetic: pcs modulo 2^XLEN, wrap 0xFFFF_FFFC → 0 silently. Counters $clog2(DEPTH+1) bits.
- Reset values: imem_req_valid=0 during reset, out_valid=0, out_trap=0, out_instr=0, out_pc=RESET_PC, out_pc_4=RESET_PC+4, inflight=drop_cnt=count=0. Reset mid-operation abandons outstanding responses; memory must not respond after reset.

## Timing
- First request in first cycle after reset deasserts.
- Response pushed registered: out_valid rises the cycle after imem_rsp_valid.
- With 1-cycle memory and out_ready=1: one instruction per cycle sustained (DEPTH ≥ 2).
- Redirect at cycle N: out_valid=0 at N+1; new request at N+1; new-path out_valid earliest N+3 with 1-cycle memory.
- out_* outputs driven from queue head registers; stable while out_valid && !out_ready.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0] ≠ 0 → state TRAP, single entry pushed {pc=redirect_pc, instr=32'h0000_0013, trap=1}; no requests until next redirect or reset.
- Undefined: redirect_pc[1:0] forced to 0, out_trap tied 0, TRAP state absent.

## Structure
- Package fetch_pkg: NOP_INSTR (32'h0000_0013), state enum {RUN, HALTED, TRAP}, queue entry width constant.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with clear, push, pop, count; control FSM and counters in top.

## Test plan
- Reset, 1-cycle memory returning addr as data, out_ready=1 → out_pc 0,4,8,… each cycle, out_instr=out_pc, out_pc_4=out_pc+4.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, out_valid held, head pc=0 stable; release → 0,4,8,12 in order, no loss.
- 3-cycle memory, redirect to 0x100 with 2 outstanding → both stale responses dropped; next out_pc=0x100.
- Redirect coinciding with imem_rsp_valid → that response dropped, drop_cnt=inflight−1, no stale output.
- halt=1 at steady state → requests stop, outstanding drain to queue, resume at next sequential pc after halt=0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → out_trap=1, out_pc=0x102, out_instr=0x13, no requests until redirect to 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the prefetching fetch stage.
//   NOP_INSTR   - canonical NOP (addi x0,x0,0) carried by a misaligned-fetch trap entry
//   fetch_state_e - control FSM states {RUN, HALTED, TRAP}
//   entry_width - width of one prefetch queue entry ({trap?, pc, instr})
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        TRAP   = 2'd2
    } fetch_state_e;

    // Entry holds pc and instruction word, plus a trap flag when the
    // misaligned-fetch trap feature is built in.
    function automatic int entry_width(input int xlen, input bit with_trap);
        return 2 * xlen + (with_trap ? 1 : 0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO used as the prefetch queue.
//   clk, reset     - clock, synchronous active-high reset (pointers/count only)
//   clear          - empties the queue; a push in the same cycle lands as the sole entry
//   push/push_data - write one entry
//   pop            - discard the head entry
//   head_data      - current head entry (valid when count != 0)
//   count          - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; readers qualify it with count.
    always_ff @(posedge clk) begin
        if (push) mem[clear ? '0 : wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: latency-tolerant, credit-limited instruction fetch stage.
// Issues in-order word requests to instruction memory, queues returned words in a
// DEPTH-entry prefetch queue and presents {pc, pc+4, instr} to decode.
//   clk, reset            - clock, synchronous active-high reset
//   redirect, redirect_pc - branch/jump flush pulse and its target
//   halt                  - suppress new requests while high
//   imem_req_*            - request channel (valid/ready, byte address)
//   imem_rsp_*            - in-order response channel, no backpressure
//   out_valid/out_ready   - decode handshake; out_instr, out_pc, out_pc_4, out_trap
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// produces a single trap entry and stops fetch until the next redirect).
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_4,
    output logic            out_trap
);

    localparam int CW = $clog2(DEPTH+1);
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam int EW = entry_width(XLEN, 1'b1);
`else
    localparam int EW = entry_width(XLEN, 1'b0);
`endif

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;

    logic [XLEN-1:0] tgt_pc;
    logic            tgt_trap;
    logic [CW:0]     credits_used;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_push;
    logic            q_push;
    logic            q_pop;
    logic [EW-1:0]   q_push_data;
    logic [EW-1:0]   q_head;
    logic [CW-1:0]   q_count;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            head_trap;
    assign tgt_pc   = redirect_pc;
    assign tgt_trap = redirect && (redirect_pc[1:0] != 2'b00);
    assign {head_trap, head_pc, head_instr} = q_head;
`else
    assign tgt_pc   = redirect_pc & ~XLEN'(3);
    assign tgt_trap = 1'b0;
    assign {head_pc, head_instr} = q_head;
`endif

    // Queue entries plus outstanding requests never exceed DEPTH, so every
    // response that arrives is guaranteed a free slot.
    assign credits_used   = (CW+1)'(q_count) + (CW+1)'(inflight);
    assign imem_req_valid = !reset && !halt && !redirect && (state != TRAP)
                            && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = (drop_cnt != '0);
    assign rsp_push = imem_rsp_valid && !rsp_drop && !redirect;
    assign q_push   = rsp_push || tgt_trap;
    assign q_pop    = out_valid && out_ready && !redirect;

    always_comb begin
        q_push_data = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt_trap) q_push_data = {1'b1, tgt_pc, XLEN'(NOP_INSTR)};
        else          q_push_data = {1'b0, rsp_pc, imem_rsp_data};
`else
        q_push_data = {rsp_pc, imem_rsp_data};
`endif
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            if (tgt_trap)  state_nxt = TRAP;
            else if (halt) state_nxt = HALTED;
            else           state_nxt = RUN;
        end else if (state != TRAP) begin
            state_nxt = halt ? HALTED : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= tgt_pc;
                rsp_pc   <= tgt_pc;
                // Everything still outstanding belongs to the old path; a
                // response landing this very cycle is discarded right here.
                inflight <= inflight - CW'(imem_rsp_valid);
                drop_cnt <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_push) rsp_pc   <= rsp_pc + XLEN'(4);
                inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
                if (imem_rsp_valid && rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Head entry is only meaningful when the queue holds something; otherwise
    // present the reset-time values.
    assign out_valid = (q_count != '0);
    assign out_instr = out_valid ? head_instr : '0;
    assign out_pc    = out_valid ? head_pc : RESET_PC;
    assign out_pc_4  = out_pc + XLEN'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign out_trap  = out_valid && head_trap;
`else
    assign out_trap  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_4;
    logic        out_trap;

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_4       (out_pc_4),
        .out_trap       (out_trap)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: memory with per-request latency, and the
    // architectural expectation of request and delivery order.
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    bit          rdy_rand = 1'b0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] exp_out_pc = RESET_PC;
    bit          trap_mode = 1'b0;
    bit          trap_pending = 1'b0;
    int          fire_cnt = 0;
    int          hs_cnt = 0;
    int          redir_rsp_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] tgt;
        int          due;
        cyc++;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            last_due       = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_req_ready = 1'b1;
            exp_req_pc     = RESET_PC;
            exp_out_pc     = RESET_PC;
            trap_mode      = 1'b0;
            trap_pending   = 1'b0;
        end else begin
            imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (redirect) begin
                check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
                tgt = redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_mode    = (tgt[1:0] != 2'b00);
                trap_pending = trap_mode;
`else
                tgt = tgt & ~32'd3;
`endif
                exp_req_pc = tgt;
                exp_out_pc = tgt;
            end else begin
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (trap_pending) begin
                        check("trap_flag", 32'(out_trap), 32'd1);
                        check("trap_pc", out_pc, exp_out_pc);
                        check("trap_instr", out_instr, 32'h0000_0013);
                        trap_pending = 1'b0;
                    end else if (trap_mode) begin
                        check("output_after_trap", 32'(out_valid), 32'd0);
                    end else begin
                        check("out_pc", out_pc, exp_out_pc);
                        check("out_instr", out_instr, exp_out_pc ^ KEY);
                        check("out_pc_4", out_pc_4, exp_out_pc + 32'd4);
                        check("out_trap", 32'(out_trap), 32'd0);
                        exp_out_pc = exp_out_pc + 32'd4;
                    end
                end
                if (halt || trap_mode)
                    check("no_req_while_stopped", 32'(imem_req_valid), 32'd0);
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_req_pc);
                    due = cyc + lat;
                    if (due < last_due) due = last_due;
                    last_due = due;
                    q_addr.push_back(imem_req_addr);
                    q_due.push_back(due);
                    exp_req_pc = exp_req_pc + 32'd4;
                    fire_cnt++;
                end
            end
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = q_addr.pop_front() ^ KEY;
                void'(q_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            if (redirect && imem_rsp_valid) redir_rsp_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        step(1);
        redirect    = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n = 0;
        while (!out_valid && n < maxc) begin
            step(1);
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_trap", 32'(out_trap), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, RESET_PC);
        check("rst_out_pc_4", out_pc_4, RESET_PC + 32'd4);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        int base;
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        step(3);
        check_reset_outputs();

        // Decode stalled from the start: credits cap outstanding work at DEPTH.
        fire_cnt = 0;
        reset    = 1'b0;
        #1;
        check("first_req_after_reset", 32'(imem_req_valid), 32'd1);
        step(10);
        check("stall_req_count", 32'(fire_cnt), 32'(DEPTH));
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head_pc", out_pc, RESET_PC);
        check("stall_head_instr", out_instr, RESET_PC ^ KEY);

        // Release: sustained one instruction per cycle with 1-cycle memory.
        out_ready = 1'b1;
        base = hs_cnt;
        step(20);
        check("throughput", 32'(hs_cnt - base), 32'd20);

        // 3-cycle memory, redirect with several responses still outstanding.
        lat = 3;
        step(10);
        check("outstanding_ge2", 32'(q_addr.size() >= 2), 32'd1);
        do_redirect(32'h0000_0100);
        check("redir_out_valid_low", 32'(out_valid), 32'd0);
        check("redir_new_req", imem_req_addr, 32'h0000_0100);
        wait_valid(20, "redir_timeout");
        check("redir_first_pc", out_pc, 32'h0000_0100);

        // Redirect on a cycle where a response arrives.
        lat = 1;
        step(8);
        base = redir_rsp_cnt;
        do_redirect(32'h0000_0300);
        check("redir_with_rsp", 32'(redir_rsp_cnt - base), 32'd1);
        check("redir2_out_valid_low", 32'(out_valid), 32'd0);
        wait_valid(20, "redir2_timeout");
        check("redir2_first_pc", out_pc, 32'h0000_0300);

        // Halt: requests stop, outstanding responses drain, then resume in sequence.
        lat = 2;
        step(8);
        halt = 1'b1;
        step(10);
        check("halt_mem_drained", 32'(q_addr.size()), 32'd0);
        check("halt_queue_drained", 32'(out_valid), 32'd0);
        halt = 1'b0;
        #1;
        check("resume_req_valid", 32'(imem_req_valid), 32'd1);
        check("resume_req_addr", imem_req_addr, exp_req_pc);
        step(10);

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
        do_redirect(32'h0000_0102);
        check("trap_out_valid", 32'(out_valid), 32'd1);
        check("trap_out_trap", 32'(out_trap), 32'd1);
        check("trap_out_pc", out_pc, 32'h0000_0102);
        check("trap_out_instr", out_instr, 32'h0000_0013);
        base = fire_cnt;
        step(10);
        check("trap_no_requests", 32'(fire_cnt - base), 32'd0);
        do_redirect(32'h0000_0200);
        wait_valid(20, "trap_exit_timeout");
        check("trap_exit_pc", out_pc, 32'h0000_0200);
`else
        do_redirect(32'h0000_0102);
        wait_valid(20, "misalign_timeout");
        check("misalign_forced_pc", out_pc, 32'h0000_0100);
        check("misalign_no_trap", 32'(out_trap), 32'd0);
`endif

        // Address wrap at the top of the space.
        do_redirect(32'hFFFF_FFF8);
        base = hs_cnt;
        step(12);
        check("wrap_progress", 32'(hs_cnt - base >= 6), 32'd1);

        // Randomized traffic: memory stalls, variable latency, stalls, halts, redirects.
        rdy_rand = 1'b1;
        base = hs_cnt;
        for (int i = 0; i < 1500; i++) begin
            redirect  = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            lat       = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            if ($urandom_range(0, 39) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            end
            step(1);
        end
        redirect  = 1'b0;
        halt      = 1'b0;
        out_ready = 1'b1;
        rdy_rand  = 1'b0;
        check("random_progress", 32'(hs_cnt - base > 100), 32'd1);
        do_redirect(32'h0000_0400);
        wait_valid(30, "post_random_timeout");
        check("post_random_pc", out_pc, 32'h0000_0400);

        // Reset in the middle of traffic abandons everything in flight.
        step(5);
        reset = 1'b1;
        step(2);
        check_reset_outputs();
        reset = 1'b0;
        wait_valid(10, "post_reset_timeout");
        check("post_reset_pc", out_pc, RESET_PC);
        step(10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
